// File: rtl/multi_digit_display_driver_if.sv
// multi_digit_display_driver_if: load bus and display pins of the scanned seven-segment driver
interface multi_digit_display_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digit_values;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [NUM_DIGITS-1:0]     anode_signals;
    logic [6:0]                display_out;
    logic                      dp_out;
    logic                      frame_done;

    modport master (
        output load, digit_values, blank_mask, dp_mask,
        input  anode_signals, display_out, dp_out, frame_done
    );

    modport slave (
        input  load, digit_values, blank_mask, dp_mask,
        output anode_signals, display_out, dp_out, frame_done
    );
endinterface

// File: rtl/multi_digit_display_driver.sv
// multi_digit_display_driver: tear-free time-multiplexed N-digit common-anode 7-segment driver
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module multi_digit_display_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 32768,
    parameter int GUARD_CYCLES = 256,
    parameter int CNT_W        = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    multi_digit_display_driver_if.slave   bus
);
    localparam int                IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  LAST_DWELL = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(DWELL_CYCLES - 2);
    localparam logic [CNT_W-1:0]  GUARD      = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

    logic [CNT_W-1:0]          r_dwell_cnt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [4*NUM_DIGITS-1:0]   r_sh_val;
    logic [NUM_DIGITS-1:0]     r_sh_blank;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic                      r_pending;
    logic [4*NUM_DIGITS-1:0]   r_act_val;
    logic [NUM_DIGITS-1:0]     r_act_blank;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [NUM_DIGITS-1:0]     r_anode;
    logic [6:0]                r_display;
    logic                      r_dp;
    logic                      r_frame_done;

    logic                      w_dwell_wrap;
    logic                      w_commit;
    logic                      w_commit_en;
    logic [4*NUM_DIGITS-1:0]   w_cm_val;
    logic [NUM_DIGITS-1:0]     w_cm_blank;
    logic [NUM_DIGITS-1:0]     w_cm_dp;
    logic [NUM_DIGITS-1:0]     w_sup_mask;
    logic [3:0]                w_nibble;
    logic [6:0]                w_seg;
    logic                      w_guard;
    logic                      w_blank_cur;
    logic                      w_sup_cur;
    logic                      w_dp_cur;
    logic                      w_lit;
    logic [NUM_DIGITS-1:0]     w_anode_on;

    assign w_dwell_wrap = (r_dwell_cnt == LAST_DWELL);
    assign w_commit     = w_dwell_wrap && (r_digit_idx == '0);
    assign w_commit_en  = w_commit && (bus.load || r_pending);
    assign w_cm_val     = bus.load ? bus.digit_values : r_sh_val;
    assign w_cm_blank   = bus.load ? bus.blank_mask   : r_sh_blank;
    assign w_cm_dp      = bus.load ? bus.dp_mask      : r_sh_dp;

    // dwell counter and leftmost-first digit scan
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_dwell_cnt <= '0;
            r_digit_idx <= LAST_IDX;
        end else begin
            r_dwell_cnt <= w_dwell_wrap ? '0 : r_dwell_cnt + CNT_ONE;
            if (w_dwell_wrap)
                r_digit_idx <= (r_digit_idx == '0) ? LAST_IDX : r_digit_idx - IDX_ONE;
        end
    end

    // shadow capture on load; active set only changes at the frame boundary
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sh_val    <= '0;
            r_sh_blank  <= '0;
            r_sh_dp     <= '0;
            r_pending   <= 1'b0;
            r_act_val   <= '0;
            r_act_blank <= '0;
            r_act_dp    <= '0;
        end else begin
            if (bus.load) begin
                r_sh_val   <= bus.digit_values;
                r_sh_blank <= bus.blank_mask;
                r_sh_dp    <= bus.dp_mask;
            end
            r_pending <= w_commit ? 1'b0 : (bus.load | r_pending);
            if (w_commit_en) begin
                r_act_val   <= w_cm_val;
                r_act_blank <= w_cm_blank;
                r_act_dp    <= w_cm_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_act_sup;

    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (!seen && v[4*i +: 4] == 4'h0)
                lz_mask[i] = 1'b1;
            else
                seen = 1'b1;
        end
    endfunction

    // suppression mask is frozen with the committed values
    always_ff @(posedge i_clock) begin
        if (!i_reset_n)
            r_act_sup <= '0;
        else if (w_commit_en)
            r_act_sup <= lz_mask(w_cm_val);
    end

    assign w_sup_mask = r_act_sup;
`else
    assign w_sup_mask = '0;
`endif

    assign w_nibble    = r_act_val[{r_digit_idx, 2'b00} +: 4];
    assign w_guard     = (r_dwell_cnt < GUARD);
    assign w_blank_cur = r_act_blank[r_digit_idx];
    assign w_sup_cur   = w_sup_mask[r_digit_idx];
    assign w_dp_cur    = r_act_dp[r_digit_idx];
    assign w_lit       = !w_guard && !w_blank_cur && (!w_sup_cur || w_dp_cur);
    assign w_anode_on  = ~(NUM_DIGITS'(1) << r_digit_idx);

    // active-low hex decode, segment order {a,b,c,d,e,f,g}
    always_comb begin
        w_seg = 7'h7F;
        case (w_nibble)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            default: w_seg = 7'b0111000;
        endcase
    end

    // registered pins; frame_done is timed to be high during the commit cycle itself
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_anode      <= '1;
            r_display    <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= w_lit ? w_anode_on : '1;
            r_display    <= (w_blank_cur || w_sup_cur) ? 7'h7F : w_seg;
            r_dp         <= w_lit ? ~w_dp_cur : 1'b1;
            r_frame_done <= (r_digit_idx == '0) && (r_dwell_cnt == PRE_LAST);
        end
    end

    assign bus.anode_signals = r_anode;
    assign bus.display_out   = r_display;
    assign bus.dp_out        = r_dp;
    assign bus.frame_done    = r_frame_done;
endmodule
